// File: rtl/tape_reader.sv
// Post-halt readout engine: walks the whole tape RAM once after the TM core halts,
// streams every cell on a valid/ready port and counts non-blank cells into sigma.
module tape_reader #(
  parameter int ADDR_W = 6,
  parameter int SYM_W  = 3,
  parameter int NSYM   = 5
) (
  input  logic              CLK_n,
  input  logic              RST,
  input  logic              halt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [SYM_W-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [ADDR_W:0]   sigma,
  output logic              done,
  output logic              err_sym,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [SYM_W:0]    NSYM_W    = (SYM_W+1)'(NSYM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t state;
  logic   halt_q;
  logic   sym_bad;
  logic   sym_counted;

  // Classification of the beat currently on the output port.
  assign sym_bad     = ({1'b0, out_sym} >= NSYM_W);
  assign sym_counted = (out_sym != '0) && !sym_bad;

  // halt passes through one flop before the FSM looks at it, which is what puts the
  // first beat three edges after the edge that samples halt.
  always_ff @(posedge CLK_n) begin
    if (RST) begin
      state     <= S_IDLE;
      halt_q    <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      sigma     <= '0;
      done      <= 1'b0;
      err_sym   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      halt_q <= halt;
      case (state)
        S_IDLE: begin
          if (halt_q) begin
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_sym   <= rd_data;
          out_addr  <= rd_addr;
          out_last  <= (rd_addr == LAST_ADDR);
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            sigma     <= sigma + {{ADDR_W{1'b0}}, sym_counted};
            err_sym   <= err_sym | sym_bad;
            out_valid <= 1'b0;
            // The walk ends on the last cell; rd_addr is never advanced past it.
            if (out_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tape_reader.sv
// Directed bench for tape_reader: a small synchronous RAM model feeds the reader and each
// scenario task checks beats, timing, sigma and the sticky flags against hand-worked values.
module tb_tape_reader;

  logic       CLK_n;
  logic       RST;
  logic       halt;
  logic [5:0] rd_addr;
  logic [2:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_sym;
  logic [5:0] out_addr;
  logic       out_last;
  logic [6:0] sigma;
  logic       done;
  logic       err_sym;
  logic       busy;

  logic [2:0] mem [64];

  int checks = 0;
  int errors = 0;

  tape_reader #(.ADDR_W(6), .SYM_W(3), .NSYM(5)) dut (
    .CLK_n    (CLK_n),
    .RST      (RST),
    .halt     (halt),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sym  (out_sym),
    .out_addr (out_addr),
    .out_last (out_last),
    .sigma    (sigma),
    .done     (done),
    .err_sym  (err_sym),
    .busy     (busy)
  );

  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;

  // Tape RAM with one cycle of read latency.
  initial rd_data = '0;
  always @(posedge CLK_n) rd_data <= mem[rd_addr];

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_dut();
    RST = 1'b1;
    halt = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK_n);
    RST = 1'b0;
  endtask

  // Waits (bounded) for out_valid; gap is the number of negedges waited, -1 on timeout.
  task automatic next_beat(output int gap);
    gap = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK_n);
      if (out_valid === 1'b1) begin
        gap = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    RST = 1'b1;
    halt = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 3'd0;
    repeat (2) @(negedge CLK_n);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (rd_addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
    checks++; if (out_sym !== 3'd0 || out_addr !== 6'd0 || out_last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_beat: got sym %0d addr %0d last %b expected 0 0 0", out_sym, out_addr, out_last);
    end
    checks++; if (sigma !== 7'd0) begin errors++; $display("[TB] FAIL reset_sigma: got %0d expected 0", sigma); end
    checks++; if (done !== 1'b0 || err_sym !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got done %b err %b busy %b expected 0 0 0", done, err_sym, busy);
    end
    RST = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge CLK_n);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_all_zero();
    int gap;
    for (int i = 0; i < 64; i++) mem[i] = 3'd0;
    reset_dut();
    halt = 1'b1;
    for (int b = 0; b < 64; b++) begin
      next_beat(gap);
      checks++; if (gap !== ((b == 0) ? 4 : 3)) begin
        errors++; $display("[TB] FAIL zero_gap beat %0d: got %0d expected %0d", b, gap, (b == 0) ? 4 : 3);
      end
      if (gap < 0) break;
      checks++; if (out_addr !== 6'(b)) begin errors++; $display("[TB] FAIL zero_addr beat %0d: got %0d", b, out_addr); end
      checks++; if (out_last !== (b == 63)) begin errors++; $display("[TB] FAIL zero_last beat %0d: got %b expected %b", b, out_last, b == 63); end
      checks++; if (out_sym !== 3'd0) begin errors++; $display("[TB] FAIL zero_sym beat %0d: got %0d expected 0", b, out_sym); end
    end
    @(negedge CLK_n);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    checks++; if (sigma !== 7'd0) begin errors++; $display("[TB] FAIL zero_sigma: got %0d expected 0", sigma); end
    checks++; if (err_sym !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_end_flags: got err %b busy %b valid %b expected 0 0 0", err_sym, busy, out_valid);
    end
  endtask

  task automatic test_sigma_count();
    int gap;
    for (int i = 0; i < 64; i++) mem[i] = (i >= 10 && i <= 46) ? 3'(((i - 10) % 4) + 1) : 3'd0;
    reset_dut();
    halt = 1'b1;
    for (int b = 0; b < 64; b++) begin
      next_beat(gap);
      checks++; if (gap !== ((b == 0) ? 4 : 3)) begin
        errors++; $display("[TB] FAIL sigma_gap beat %0d: got %0d expected %0d", b, gap, (b == 0) ? 4 : 3);
      end
      if (gap < 0) break;
      checks++; if (out_addr !== 6'(b) || out_sym !== mem[b]) begin
        errors++; $display("[TB] FAIL sigma_beat %0d: got addr %0d sym %0d expected sym %0d", b, out_addr, out_sym, mem[b]);
      end
      // Halt dropping mid-walk must not stop the dump.
      if (b == 20) halt = 1'b0;
    end
    @(negedge CLK_n);
    checks++; if (sigma !== 7'd37) begin errors++; $display("[TB] FAIL sigma_final: got %0d expected 37", sigma); end
    checks++; if (done !== 1'b1 || err_sym !== 1'b0) begin
      errors++; $display("[TB] FAIL sigma_flags: got done %b err %b expected 1 0", done, err_sym);
    end
  endtask

  task automatic test_backpressure();
    int gap;
    for (int i = 0; i < 64; i++) mem[i] = 3'(i % 4);
    reset_dut();
    halt = 1'b1;
    for (int b = 0; b < 64; b++) begin
      next_beat(gap);
      checks++; if (gap !== ((b == 0) ? 4 : 3)) begin
        errors++; $display("[TB] FAIL bp_gap beat %0d: got %0d expected %0d", b, gap, (b == 0) ? 4 : 3);
      end
      if (gap < 0) break;
      checks++; if (out_addr !== 6'(b) || out_sym !== mem[b]) begin
        errors++; $display("[TB] FAIL bp_beat %0d: got addr %0d sym %0d expected sym %0d", b, out_addr, out_sym, mem[b]);
      end
      if (b == 5) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge CLK_n);
          checks++; if (out_valid !== 1'b1 || out_addr !== 6'd5 || out_sym !== 3'd1 || sigma !== 7'd3) begin
            errors++; $display("[TB] FAIL bp_hold: got valid %b addr %0d sym %0d sigma %0d expected 1 5 1 3",
                               out_valid, out_addr, out_sym, sigma);
          end
        end
        out_ready = 1'b1;
      end
      if (b == 6) begin
        checks++; if (sigma !== 7'd4) begin errors++; $display("[TB] FAIL bp_sigma_after: got %0d expected 4", sigma); end
      end
    end
    @(negedge CLK_n);
    checks++; if (sigma !== 7'd48 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_final: got sigma %0d done %b expected 48 1", sigma, done);
    end
  endtask

  task automatic test_bad_symbol();
    int gap;
    for (int i = 0; i < 64; i++) mem[i] = 3'd0;
    mem[20] = 3'd6;
    reset_dut();
    halt = 1'b1;
    for (int b = 0; b < 64; b++) begin
      next_beat(gap);
      checks++; if (gap !== ((b == 0) ? 4 : 3)) begin
        errors++; $display("[TB] FAIL bad_gap beat %0d: got %0d expected %0d", b, gap, (b == 0) ? 4 : 3);
      end
      if (gap < 0) break;
      if (b == 20) begin
        checks++; if (out_sym !== 3'd6 || err_sym !== 1'b0) begin
          errors++; $display("[TB] FAIL bad_before: got sym %0d err %b expected 6 0", out_sym, err_sym);
        end
      end
      if (b == 21) begin
        checks++; if (err_sym !== 1'b1) begin errors++; $display("[TB] FAIL bad_after: got err %b expected 1", err_sym); end
      end
    end
    @(negedge CLK_n);
    checks++; if (err_sym !== 1'b1 || sigma !== 7'd0 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_final: got err %b sigma %0d done %b expected 1 0 1", err_sym, sigma, done);
    end
  endtask

  task automatic test_reset_mid_dump();
    int gap;
    for (int i = 0; i < 64; i++) mem[i] = 3'(i % 4);
    reset_dut();
    halt = 1'b1;
    for (int b = 0; b <= 30; b++) begin
      next_beat(gap);
      if (gap < 0) break;
    end
    checks++; if (out_valid !== 1'b1 || out_addr !== 6'd30) begin
      errors++; $display("[TB] FAIL abort_reach: got valid %b addr %0d expected 1 30", out_valid, out_addr);
    end
    RST = 1'b1;
    @(negedge CLK_n);
    checks++; if (out_valid !== 1'b0 || out_addr !== 6'd0 || sigma !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_reset: got valid %b addr %0d sigma %0d busy %b done %b expected 0 0 0 0 0",
                         out_valid, out_addr, sigma, busy, done);
    end
    RST = 1'b0;
    for (int b = 0; b < 64; b++) begin
      next_beat(gap);
      checks++; if (gap !== ((b == 0) ? 4 : 3)) begin
        errors++; $display("[TB] FAIL restart_gap beat %0d: got %0d expected %0d", b, gap, (b == 0) ? 4 : 3);
      end
      if (gap < 0) break;
      checks++; if (out_addr !== 6'(b)) begin errors++; $display("[TB] FAIL restart_addr beat %0d: got %0d", b, out_addr); end
    end
    @(negedge CLK_n);
    checks++; if (sigma !== 7'd48 || done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL restart_final: got sigma %0d done %b valid %b expected 48 1 0", sigma, done, out_valid);
    end
  endtask

  initial begin
    $display("[TB] starting tape_reader bench");
    test_reset();
    test_all_zero();
    test_sigma_count();
    test_backpressure();
    test_bad_symbol();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
